// File: rtl/io_timeout_guard64fta_if.sv
// FTA 64-bit command request/response types and the timeout guard bus.
// Master side is the bridge/device pair, slave side is the guard.
package io_timeout_guard64fta_pkg;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  sel;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [31:0] padr;
    logic [63:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic        stall;
    logic        next;
    logic        ack;
    logic        err;
    logic        rty;
    logic        pri;
    logic [31:0] adr;
    logic [63:0] dat;
  } fta_cmd_response64_t;
endpackage

interface io_timeout_guard64fta_if;
  import io_timeout_guard64fta_pkg::*;

  fta_cmd_request64_t  req_i;
  fta_cmd_response64_t resp_i;
  fta_cmd_response64_t resp_o;
  logic                full_o;
  logic [15:0]         tmo_cnt_o;
  logic [15:0]         late_cnt_o;
  logic [15:0]         drop_cnt_o;

  modport master (
    output req_i, resp_i,
    input  resp_o, full_o,
    input  tmo_cnt_o, late_cnt_o, drop_cnt_o
  );

  modport slave (
    input  req_i, resp_i,
    output resp_o, full_o,
    output tmo_cnt_o, late_cnt_o, drop_cnt_o
  );
endinterface

// File: rtl/io_timeout_guard64fta.sv
// Tracks outstanding FTA requests by {cid,tid}, forwards device responses,
// and synthesizes err on timeout and rty when the tracker is full.
module io_timeout_guard64fta
  import io_timeout_guard64fta_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 1023,
  parameter bit          TRACK_WR = 1'b1,
  parameter logic [63:0] ERRDAT   = 64'hDEADDEADDEADDEAD
) (
  input logic clk_i,
  input logic rst_i,
  io_timeout_guard64fta_if.slave bus
);
  localparam int          IW  = $clog2(DEPTH);
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  localparam logic [15:0] SAT = 16'hFFFF;

  fta_cmd_request64_t  req;
  fta_cmd_response64_t rin;
  fta_cmd_response64_t resp_q;

  logic [DEPTH-1:0] vld_q;
  logic [3:0]       cid_q [DEPTH];
  logic [7:0]       tid_q [DEPTH];
  logic [31:0]      adr_q [DEPTH];
  logic [15:0]      age_q [DEPTH];

  logic        rej_q;
  logic [3:0]  rcid_q;
  logic [7:0]  rtid_q;
  logic [31:0] radr_q;

  logic        pcs_q;
  logic [11:0] pkey_q;
  logic [15:0] tmo_q;
  logic [15:0] late_q;
  logic [15:0] drop_q;

  logic          cs;
  logic          cap;
  logic          rsp;
  logic          hit;
  logic          have_free;
  logic          have_exp;
  logic          new_rej;
  logic          emit_rej;
  logic          emit_tmo;
  logic          drop;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] exp_idx;

  logic unused_req;

  assign req = bus.req_i;
  assign rin = bus.resp_i;
  assign unused_req = ^{req.sel, req.dat};

  always_comb begin
    cs  = req.cyc & req.stb;
    cap = cs
        & ~(pcs_q && pkey_q == {req.cid, req.tid})
        & ~(req.we & ~TRACK_WR);
    rsp = rin.ack | rin.err | rin.rty;
    hit       = 1'b0;
    hit_idx   = '0;
    have_free = 1'b0;
    free_idx  = '0;
    have_exp  = 1'b0;
    exp_idx   = '0;
    // Descending scan so the lowest index is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rsp && vld_q[i] && cid_q[i] == rin.cid
          && tid_q[i] == rin.tid) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!vld_q[i]) begin
        have_free = 1'b1;
        free_idx  = IW'(i);
      end
      if (vld_q[i] && age_q[i] == TMO) begin
        have_exp = 1'b1;
        exp_idx  = IW'(i);
      end
    end
    new_rej  = cap & ~have_free;
    emit_rej = ~hit & (rej_q | new_rej);
    emit_tmo = ~hit & ~emit_rej & have_exp;
    drop     = new_rej & rej_q & ~emit_rej;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cid_q[i] <= '0;
        tid_q[i] <= '0;
        adr_q[i] <= '0;
        age_q[i] <= '0;
      end
      rej_q  <= 1'b0;
      rcid_q <= '0;
      rtid_q <= '0;
      radr_q <= '0;
      pcs_q  <= 1'b0;
      pkey_q <= '0;
      resp_q <= '0;
      tmo_q  <= '0;
      late_q <= '0;
      drop_q <= '0;
    end else begin
      pcs_q  <= cs;
      pkey_q <= {req.cid, req.tid};
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && age_q[i] != TMO)
          age_q[i] <= age_q[i] + 16'd1;
      end
      if (hit)
        vld_q[hit_idx] <= 1'b0;
      if (emit_tmo)
        vld_q[exp_idx] <= 1'b0;
      if (cap && have_free) begin
        vld_q[free_idx] <= 1'b1;
        cid_q[free_idx] <= req.cid;
        tid_q[free_idx] <= req.tid;
        adr_q[free_idx] <= req.padr;
        age_q[free_idx] <= '0;
      end

      // A pending reject leaving this cycle makes room for a new one.
      rej_q <= emit_rej ? (rej_q & new_rej) : (rej_q | new_rej);
      if (new_rej && !drop) begin
        rcid_q <= req.cid;
        rtid_q <= req.tid;
        radr_q <= req.padr;
      end

      resp_q <= '0;
      unique case (1'b1)
        hit: resp_q <= rin;
        emit_rej: begin
          resp_q.rty <= 1'b1;
          resp_q.cid <= rej_q ? rcid_q : req.cid;
          resp_q.tid <= rej_q ? rtid_q : req.tid;
          resp_q.adr <= rej_q ? radr_q : req.padr;
          resp_q.dat <= ERRDAT;
        end
        emit_tmo: begin
          resp_q.err <= 1'b1;
          resp_q.cid <= cid_q[exp_idx];
          resp_q.tid <= tid_q[exp_idx];
          resp_q.adr <= adr_q[exp_idx];
          resp_q.dat <= ERRDAT;
        end
        default: ;
      endcase

      if (emit_tmo && tmo_q != SAT)
        tmo_q <= tmo_q + 16'd1;
      if (rsp && !hit && late_q != SAT)
        late_q <= late_q + 16'd1;
      if (drop && drop_q != SAT)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign bus.resp_o     = resp_q;
  assign bus.full_o     = &vld_q;
  assign bus.tmo_cnt_o  = tmo_q;
  assign bus.late_cnt_o = late_q;
  assign bus.drop_cnt_o = drop_q;
endmodule

// File: tb/tb_io_timeout_guard64fta.sv
// Directed scenarios plus randomized traffic checked against a
// timestamp/queue model of the timeout guard.
module tb_io_timeout_guard64fta;
  import io_timeout_guard64fta_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          TMO    = 16;
  localparam logic [63:0] ERRDAT = 64'hDEADDEADDEADDEAD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  io_timeout_guard64fta_if bus();

  io_timeout_guard64fta #(
    .DEPTH(DEPTH),
    .TIMEOUT(TMO),
    .TRACK_WR(1'b1),
    .ERRDAT(ERRDAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [3:0]  cid;
    logic [7:0]  tid;
    logic [31:0] adr;
    int          t;
  } ent_t;

  ent_t                m_e [DEPTH];
  fta_cmd_response64_t m_rej [$];
  fta_cmd_response64_t m_resp;
  int                  now;
  bit                  m_pcs;
  logic [11:0]         m_pkey;
  int                  m_tmo;
  int                  m_late;
  int                  m_drop;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_e[i].v = 1'b0;
    m_rej.delete();
    m_resp = '0;
    now = 0;
    m_pcs = 1'b0;
    m_pkey = '0;
    m_tmo = 0;
    m_late = 0;
    m_drop = 0;
  endfunction

  function automatic bit model_full();
    bit f = 1'b1;
    for (int i = 0; i < DEPTH; i++) f &= m_e[i].v;
    return f;
  endfunction

  task automatic idle();
    bus.req_i = '0;
    bus.resp_i = '0;
  endtask

  task automatic send_req(input logic [3:0] c, input logic [7:0] t);
    fta_cmd_request64_t q = '0;
    q.cyc = 1'b1;
    q.stb = 1'b1;
    q.cid = c;
    q.tid = t;
    q.padr = {16'hA000, 8'(c), t};
    bus.req_i = q;
  endtask

  task automatic send_ack(input logic [3:0] c, input logic [7:0] t,
                          input logic [63:0] d);
    fta_cmd_response64_t r = '0;
    r.ack = 1'b1;
    r.cid = c;
    r.tid = t;
    r.dat = d;
    bus.resp_i = r;
  endtask

  // One clock: advance the model on the current inputs, then the DUT edge.
  task automatic tick();
    fta_cmd_request64_t  q = bus.req_i;
    fta_cmd_response64_t r = bus.resp_i;
    fta_cmd_response64_t o = '0;
    fta_cmd_response64_t rj;
    bit cap, rsp;
    int hit = -1;
    int fr = -1;
    int ex = -1;
    now++;
    cap = q.cyc && q.stb && !(m_pcs && m_pkey == {q.cid, q.tid});
    m_pcs = q.cyc && q.stb;
    m_pkey = {q.cid, q.tid};
    rsp = r.ack | r.err | r.rty;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_e[i].v && rsp && m_e[i].cid == r.cid && m_e[i].tid == r.tid)
        hit = i;
      if (!m_e[i].v) fr = i;
      if (m_e[i].v && now - m_e[i].t > TMO) ex = i;
    end
    if (rsp && hit < 0) m_late++;
    if (cap && fr < 0) begin
      rj = '0;
      rj.rty = 1'b1;
      rj.cid = q.cid;
      rj.tid = q.tid;
      rj.adr = q.padr;
      rj.dat = ERRDAT;
      m_rej.push_back(rj);
    end
    if (hit >= 0) begin
      o = r;
      m_e[hit].v = 1'b0;
    end else if (m_rej.size() > 0) begin
      o = m_rej.pop_front();
    end else if (ex >= 0) begin
      o.err = 1'b1;
      o.cid = m_e[ex].cid;
      o.tid = m_e[ex].tid;
      o.adr = m_e[ex].adr;
      o.dat = ERRDAT;
      m_e[ex].v = 1'b0;
      m_tmo++;
    end
    if (m_rej.size() > 1) begin
      void'(m_rej.pop_back());
      m_drop++;
    end
    if (cap && fr >= 0) begin
      m_e[fr].v = 1'b1;
      m_e[fr].cid = q.cid;
      m_e[fr].tid = q.tid;
      m_e[fr].adr = q.padr;
      m_e[fr].t = now;
    end
    m_resp = o;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.resp_o !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0", bus.resp_o);
    end
    checks++;
    if (bus.full_o !== 1'b0 || bus.tmo_cnt_o !== 16'd0
        || bus.late_cnt_o !== 16'd0 || bus.drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: full %b tmo %0d late %0d drop %0d want 0",
               bus.full_o, bus.tmo_cnt_o, bus.late_cnt_o, bus.drop_cnt_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_ack();
    logic [63:0] d = {$urandom, $urandom};
    send_req(4'd1, 8'd5);
    tick();
    idle();
    tick();
    tick();
    send_ack(4'd1, 8'd5, d);
    tick();
    idle();
    checks++;
    if (bus.resp_o.ack !== 1'b1 || bus.resp_o.cid !== 4'd1
        || bus.resp_o.tid !== 8'd5 || bus.resp_o.dat !== d) begin
      errors++;
      $display("FAIL read_ack: got ack %b cid %0d tid %0d dat %h want 1 1 5 %h",
               bus.resp_o.ack, bus.resp_o.cid, bus.resp_o.tid,
               bus.resp_o.dat, d);
    end
    tick();
    checks++;
    if (bus.resp_o.ack !== 1'b0 || bus.tmo_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL read_ack_after: ack %b tmo %0d want 0 0",
               bus.resp_o.ack, bus.tmo_cnt_o);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    send_req(4'd2, 8'd7);
    tick();
    idle();
    for (int i = 0; i < TMO; i++) begin
      tick();
      if (bus.resp_o.err) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d err pulses want 0", early);
    end
    tick();
    checks++;
    if (bus.resp_o.err !== 1'b1 || bus.resp_o.tid !== 8'd7
        || bus.resp_o.dat !== ERRDAT || bus.resp_o.pri !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: got err %b tid %0d dat %h want 1 7 %h",
               bus.resp_o.err, bus.resp_o.tid, bus.resp_o.dat, ERRDAT);
    end
    checks++;
    if (bus.tmo_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL timeout_cnt: got %0d want 1", bus.tmo_cnt_o);
    end
  endtask

  task automatic test_late();
    send_ack(4'd2, 8'd7, 64'h1234);
    tick();
    idle();
    checks++;
    if (bus.resp_o.ack !== 1'b0 || bus.late_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL late_drop: got ack %b late %0d want 0 1",
               bus.resp_o.ack, bus.late_cnt_o);
    end
  endtask

  task automatic test_full();
    logic [7:0] got [$];
    for (int i = 0; i < 4; i++) begin
      send_req(4'd3, 8'(10 + i));
      tick();
    end
    checks++;
    if (bus.full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_flag: got %b want 1", bus.full_o);
    end
    send_req(4'd3, 8'd14);
    tick();
    idle();
    checks++;
    if (bus.resp_o.rty !== 1'b1 || bus.resp_o.tid !== 8'd14
        || bus.resp_o.adr !== 32'hA000030E || bus.resp_o.dat !== ERRDAT) begin
      errors++;
      $display("FAIL full_rty: got rty %b tid %0d adr %h want 1 14 a000030e",
               bus.resp_o.rty, bus.resp_o.tid, bus.resp_o.adr);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.resp_o.err) got.push_back(bus.resp_o.tid);
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL full_err_count: got %0d errs want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 8'(10 + i)) begin
          errors++;
          $display("FAIL full_err_order: slot %0d got tid %0d want %0d",
                   i, got[i], 10 + i);
        end
      end
    end
    checks++;
    if (bus.tmo_cnt_o !== 16'd5 || bus.full_o !== 1'b0) begin
      errors++;
      $display("FAIL full_after: tmo %0d full %b want 5 0",
               bus.tmo_cnt_o, bus.full_o);
    end
  endtask

  task automatic test_priority();
    send_req(4'd0, 8'd20);
    tick();
    send_req(4'd0, 8'd21);
    tick();
    send_req(4'd0, 8'd22);
    tick();
    idle();
    send_ack(4'd0, 8'd20, 64'h20);
    tick();
    send_ack(4'd0, 8'd21, 64'h21);
    tick();
    idle();
    send_req(4'd0, 8'd23);
    tick();
    idle();
    repeat (13) tick();
    checks++;
    if (bus.resp_o !== '0) begin
      errors++;
      $display("FAIL prio_quiet: got %h want 0", bus.resp_o);
    end
    send_ack(4'd0, 8'd23, 64'h23);
    tick();
    idle();
    checks++;
    if (bus.resp_o.ack !== 1'b1 || bus.resp_o.err !== 1'b0
        || bus.resp_o.tid !== 8'd23) begin
      errors++;
      $display("FAIL prio_ack: got ack %b err %b tid %0d want 1 0 23",
               bus.resp_o.ack, bus.resp_o.err, bus.resp_o.tid);
    end
    tick();
    checks++;
    if (bus.resp_o.err !== 1'b1 || bus.resp_o.tid !== 8'd22
        || bus.tmo_cnt_o !== 16'd6) begin
      errors++;
      $display("FAIL prio_err: got err %b tid %0d tmo %0d want 1 22 6",
               bus.resp_o.err, bus.resp_o.tid, bus.tmo_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send_req(4'd1, 8'(30 + i));
      tick();
    end
    idle();
    send_ack(4'd1, 8'd30, 64'h30);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.resp_o !== '0 || bus.full_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_out: resp %h full %b want 0 0",
               bus.resp_o, bus.full_o);
    end
    checks++;
    if (bus.tmo_cnt_o !== 16'd0 || bus.late_cnt_o !== 16'd0
        || bus.drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_cnt: tmo %0d late %0d drop %0d want 0",
               bus.tmo_cnt_o, bus.late_cnt_o, bus.drop_cnt_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.resp_o.err || bus.resp_o.ack || bus.resp_o.rty) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_mid_ghost: got %0d responses want 0", pulses);
    end
  endtask

  task automatic test_random();
    int                  vl [$];
    int                  k;
    int                  j;
    fta_cmd_request64_t  q;
    fta_cmd_response64_t r;
    q = '0;
    for (int c = 0; c < 3000; c++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        q = '0;
        q.cyc = 1'b1;
        q.stb = 1'b1;
        q.we = 1'($urandom);
        q.cid = 4'($urandom_range(0, 3));
        q.tid = 8'($urandom_range(0, 7));
        q.padr = $urandom;
        q.dat = {$urandom, $urandom};
      end else if (k < 7) begin
        q = '0;
      end else if (k == 7) begin
        q.stb = 1'b0;
      end
      r = '0;
      vl.delete();
      for (int i = 0; i < DEPTH; i++) if (m_e[i].v) vl.push_back(i);
      k = $urandom_range(0, 9);
      if (k < 3 && vl.size() > 0) begin
        j = vl[$urandom_range(0, vl.size() - 1)];
        r.cid = m_e[j].cid;
        r.tid = m_e[j].tid;
      end else begin
        r.cid = 4'($urandom_range(0, 3));
        r.tid = 8'($urandom_range(0, 7));
      end
      if (k < 4) begin
        case ($urandom_range(0, 2))
          0: r.ack = 1'b1;
          1: r.err = 1'b1;
          default: r.rty = 1'b1;
        endcase
        r.dat = {$urandom, $urandom};
        r.adr = $urandom;
        r.pri = 1'($urandom);
        r.next = 1'($urandom);
      end
      bus.req_i = q;
      bus.resp_i = r;
      tick();
      checks++;
      if (bus.resp_o !== m_resp) begin
        errors++;
        if (errors < 20)
          $display("FAIL rnd_resp cyc %0d: got %h want %h",
                   c, bus.resp_o, m_resp);
      end
      checks++;
      if (bus.full_o !== model_full()) begin
        errors++;
        if (errors < 20)
          $display("FAIL rnd_full cyc %0d: got %b want %b",
                   c, bus.full_o, model_full());
      end
      checks++;
      if (bus.tmo_cnt_o !== 16'(m_tmo) || bus.late_cnt_o !== 16'(m_late)
          || bus.drop_cnt_o !== 16'(m_drop)) begin
        errors++;
        if (errors < 20)
          $display("FAIL rnd_cnt cyc %0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                   c, bus.tmo_cnt_o, bus.late_cnt_o, bus.drop_cnt_o,
                   m_tmo, m_late, m_drop);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_read_ack();
    test_timeout();
    test_late();
    test_full();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
